// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX and EX/MEM pipeline registers of the
// 16-bit, 4-register CPU: widths, ALU opcodes and the bubble encoding.
package id_ex_stage_pkg;

  localparam int WORD_SIZE  = 16;
  localparam int REG_ADDR_W = 2;
  localparam int ALU_OP_W   = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_ORR = 4'd3,
    ALU_NOT = 4'd4,
    ALU_TCP = 4'd5,
    ALU_SHL = 4'd6,
    ALU_SHR = 4'd7,
    ALU_LHI = 4'd8
  } alu_op_e;

  typedef struct packed {
    logic                alu_src;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                halt;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] dest;
    logic [WORD_SIZE-1:0]  rdata1;
    logic [WORD_SIZE-1:0]  rdata2;
    logic [WORD_SIZE-1:0]  imm;
    ctrl_t                 ctrl;
  } id_ex_t;

  // A bubble is the all-zero encoding: no valid bit, no side effects.
  localparam ctrl_t  CTRL_BUBBLE  = '0;
  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: the instruction in ID reads a register that the
// load currently in EX has not yet fetched from memory.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  load_use
);

  logic rs_match;
  logic rt_match;

  assign rs_match = id_uses_rs && (id_rs == ex_dest);
  assign rt_match = id_uses_rt && (id_rt == ex_dest);
  assign load_use = ex_valid && ex_mem_read && id_valid && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles, WB-to-ID
// register bypass and saturating per-cause bubble counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [WORD_SIZE-1:0]  id_rdata1,
  input  logic [WORD_SIZE-1:0]  id_rdata2,
  input  logic [WORD_SIZE-1:0]  id_imm,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_halt,
  input  logic                  flush,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic [WORD_SIZE-1:0]  wb_data,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic [WORD_SIZE-1:0]  ex_rdata1,
  output logic [WORD_SIZE-1:0]  ex_rdata2,
  output logic [WORD_SIZE-1:0]  ex_imm,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic                  ex_alu_src,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_halt,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  id_ex_t ex_q;
  id_ex_t id_next;
  logic   load_use;
  logic   bubble;

  hazard_detect u_hazard_detect (
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.ctrl.mem_read),
    .ex_dest     (ex_q.dest),
    .load_use    (load_use)
  );

  // A flushed ID instruction is wrong-path, so holding it would be pointless.
  assign stall  = load_use && !flush && !reset;
  assign bubble = flush || load_use || !id_valid;

  // The register file is written late in the cycle, so a same-cycle WB write
  // must be bypassed into the operand latched here.
  always_comb begin
    // NOTE: default every field first so no path leaves a value held (latch).
    id_next                 = ID_EX_BUBBLE;
    id_next.valid           = id_valid;
    id_next.rs              = id_rs;
    id_next.rt              = id_rt;
    id_next.dest            = id_dest;
    id_next.imm             = id_imm;
    id_next.rdata1          = (wb_reg_write && (wb_dest == id_rs)) ? wb_data : id_rdata1;
    id_next.rdata2          = (wb_reg_write && (wb_dest == id_rt)) ? wb_data : id_rdata2;
    id_next.ctrl.alu_src    = id_alu_src;
    id_next.ctrl.reg_write  = id_reg_write;
    id_next.ctrl.mem_read   = id_mem_read;
    id_next.ctrl.mem_write  = id_mem_write;
    id_next.ctrl.mem_to_reg = id_mem_to_reg;
    id_next.ctrl.halt       = id_halt;
    id_next.ctrl.alu_op     = id_alu_op;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values.
    if (reset || bubble) begin
      ex_q <= ID_EX_BUBBLE;
    end else begin
      ex_q <= id_next;
    end
  end

  // Counters saturate so a long debug run never reports a misleading small value.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (flush) begin
      if (flush_count != '1) flush_count <= flush_count + CNT_ONE;
    end else if (load_use) begin
      if (stall_count != '1) stall_count <= stall_count + CNT_ONE;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_dest       = ex_q.dest;
  assign ex_rdata1     = ex_q.rdata1;
  assign ex_rdata2     = ex_q.rdata2;
  assign ex_imm        = ex_q.imm;
  assign ex_alu_op     = ex_q.ctrl.alu_op;
  assign ex_alu_src    = ex_q.ctrl.alu_src;
  assign ex_reg_write  = ex_q.ctrl.reg_write;
  assign ex_mem_read   = ex_q.ctrl.mem_read;
  assign ex_mem_write  = ex_q.ctrl.mem_write;
  assign ex_mem_to_reg = ex_q.ctrl.mem_to_reg;
  assign ex_halt       = ex_q.ctrl.halt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push their expected
// stall/ex/counter values; a monitor pops and compares every cycle.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int CW = 3;  // narrow counters make saturation reachable

  typedef struct packed {
    logic       valid;
    logic [1:0] rs, rt, dest;
    logic       uses_rs, uses_rt;
    logic [15:0] r1, r2, imm;
    logic [3:0] op;
    logic [5:0] ctrl;  // {alu_src, reg_write, mem_read, mem_write, mem_to_reg, halt}
  } vec_t;

  typedef struct {
    string         name;
    logic          stall;
    vec_t          ex;
    logic [CW-1:0] sc, fc;
  } exp_t;

  localparam logic [5:0] C_RW   = 6'b010000;
  localparam logic [5:0] C_LW   = 6'b111010;
  localparam logic [5:0] C_SW   = 6'b100100;
  localparam logic [5:0] C_HALT = 6'b000001;
  localparam vec_t       BUB    = '0;

  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_uses_rs, id_uses_rt;
  logic [1:0] id_rs, id_rt, id_dest, wb_dest;
  logic [15:0] id_rdata1, id_rdata2, id_imm, wb_data;
  logic [3:0] id_alu_op;
  logic id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_halt;
  logic flush, wb_reg_write;
  logic stall, ex_valid;
  logic [1:0] ex_rs, ex_rt, ex_dest;
  logic [15:0] ex_rdata1, ex_rdata2, ex_imm;
  logic [3:0] ex_alu_op;
  logic ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_halt;
  logic [CW-1:0] stall_count, flush_count;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_halt(id_halt), .flush(flush),
    .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_data(wb_data),
    .stall(stall), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dest(ex_dest), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
    .ex_imm(ex_imm), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_halt(ex_halt), .stall_count(stall_count), .flush_count(flush_count)
  );

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t ins(input logic [1:0] a_rs, a_rt, a_dest,
                               input logic a_urs, a_urt,
                               input logic [15:0] a_r1, a_r2, a_imm,
                               input logic [3:0] a_op, input logic [5:0] a_ctrl);
    vec_t v;
    v = '{valid: 1'b1, rs: a_rs, rt: a_rt, dest: a_dest, uses_rs: a_urs,
          uses_rt: a_urt, r1: a_r1, r2: a_r2, imm: a_imm, op: a_op, ctrl: a_ctrl};
    return v;
  endfunction

  // The uses_* flags are not carried into EX.
  function automatic vec_t ex_of(input vec_t v);
    vec_t e;
    e = v;
    e.uses_rs = 1'b0;
    e.uses_rt = 1'b0;
    return e;
  endfunction

  task automatic issue(input string name, input logic rst, input vec_t v,
                       input logic fl, input logic wbwe, input logic [1:0] wbd,
                       input logic [15:0] wbdat, input logic exp_stall,
                       input vec_t exp_ex, input logic [CW-1:0] exp_sc, exp_fc);
    exp_t e;
    @(negedge clk);
    reset = rst;
    id_valid = v.valid; id_rs = v.rs; id_rt = v.rt; id_dest = v.dest;
    id_uses_rs = v.uses_rs; id_uses_rt = v.uses_rt;
    id_rdata1 = v.r1; id_rdata2 = v.r2; id_imm = v.imm; id_alu_op = v.op;
    {id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_halt} = v.ctrl;
    flush = fl; wb_reg_write = wbwe; wb_dest = wbd; wb_data = wbdat;
    e = '{name: name, stall: exp_stall, ex: exp_ex, sc: exp_sc, fc: exp_fc};
    sb_q.push_back(e);
  endtask

  // Monitor: stall is sampled just before the edge, registered outputs 1 ns after.
  initial begin
    exp_t e;
    logic s;
    vec_t got;
    forever begin
      @(negedge clk);
      #4 s = stall;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        got = '{valid: ex_valid, rs: ex_rs, rt: ex_rt, dest: ex_dest, uses_rs: 1'b0,
                uses_rt: 1'b0, r1: ex_rdata1, r2: ex_rdata2, imm: ex_imm, op: ex_alu_op,
                ctrl: {ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write,
                       ex_mem_to_reg, ex_halt}};
        check({e.name, " stall"}, 96'(s), 96'(e.stall));
        check({e.name, " ex"}, 96'(got), 96'(e.ex));
        check({e.name, " counters"}, 96'({stall_count, flush_count}), 96'({e.sc, e.fc}));
      end
    end
  end

  initial begin
    vec_t add1, lw2, use2, fake, lw1, use1rt, junk, byp, halt, lw3, use3, e;
    logic [CW-1:0] sc;
    add1   = ins(2'd1, 2'd2, 2'd3, 1, 1, 16'h1234, 16'h0055, 16'h0000, ALU_ADD, C_RW);
    lw2    = ins(2'd1, 2'd0, 2'd2, 1, 0, 16'h0010, 16'h0000, 16'h0004, ALU_ADD, C_LW);
    use2   = ins(2'd2, 2'd1, 2'd3, 1, 1, 16'h0A0A, 16'h0B0B, 16'h0000, ALU_SUB, C_RW);
    fake   = ins(2'd2, 2'd1, 2'd0, 0, 1, 16'h1111, 16'h2222, 16'h0000, ALU_AND, C_RW);
    lw1    = ins(2'd0, 2'd0, 2'd1, 1, 0, 16'h0020, 16'h0000, 16'h0008, ALU_ADD, C_LW);
    use1rt = ins(2'd0, 2'd1, 2'd2, 1, 1, 16'h0030, 16'h5555, 16'h0002, ALU_ADD, C_SW);
    junk   = use1rt;
    junk.valid = 1'b0;
    byp    = ins(2'd1, 2'd2, 2'd0, 0, 1, 16'h0000, 16'h2222, 16'h0000, ALU_ORR, C_RW);
    halt   = ins(2'd0, 2'd0, 2'd0, 0, 0, 16'h0000, 16'h0000, 16'h0000, ALU_ADD, C_HALT);
    lw3    = ins(2'd0, 2'd0, 2'd3, 1, 0, 16'h0040, 16'h0000, 16'h0001, ALU_ADD, C_LW);
    use3   = ins(2'd3, 2'd0, 2'd1, 1, 0, 16'h0077, 16'h0000, 16'h0000, ALU_SHL, C_RW);

    issue("reset",       1, add1,   0, 0, 2'd0, 16'h0000, 0, BUB,          3'd0, 3'd0);
    issue("normal",      0, add1,   0, 0, 2'd0, 16'h0000, 0, ex_of(add1),  3'd0, 3'd0);
    issue("load",        0, lw2,    0, 0, 2'd0, 16'h0000, 0, ex_of(lw2),   3'd0, 3'd0);
    issue("load_use",    0, use2,   0, 0, 2'd0, 16'h0000, 1, BUB,          3'd1, 3'd0);
    issue("reissue",     0, use2,   0, 0, 2'd0, 16'h0000, 0, ex_of(use2),  3'd1, 3'd0);
    issue("load2",       0, lw2,    0, 0, 2'd0, 16'h0000, 0, ex_of(lw2),   3'd1, 3'd0);
    issue("false_haz",   0, fake,   0, 0, 2'd0, 16'h0000, 0, ex_of(fake),  3'd1, 3'd0);
    issue("load1",       0, lw1,    0, 0, 2'd0, 16'h0000, 0, ex_of(lw1),   3'd1, 3'd0);
    issue("flush_haz",   0, use1rt, 1, 0, 2'd0, 16'h0000, 0, BUB,          3'd1, 3'd1);
    issue("invalid",     0, junk,   0, 0, 2'd0, 16'h0000, 0, BUB,          3'd1, 3'd1);
    e = ex_of(byp);
    e.r1 = 16'hBEEF;
    issue("wb_byp_rs",   0, byp,    0, 1, 2'd1, 16'hBEEF, 0, e,            3'd1, 3'd1);
    issue("wb_off",      0, byp,    0, 0, 2'd1, 16'hBEEF, 0, ex_of(byp),   3'd1, 3'd1);
    e = ex_of(byp);
    e.r2 = 16'hCAFE;
    issue("wb_byp_rt",   0, byp,    0, 1, 2'd2, 16'hCAFE, 0, e,            3'd1, 3'd1);
    issue("halt",        0, halt,   0, 0, 2'd0, 16'h0000, 0, ex_of(halt),  3'd1, 3'd1);
    issue("halt_flush",  0, halt,   1, 0, 2'd0, 16'h0000, 0, BUB,          3'd1, 3'd2);

    // Seven more load-use hazards: stall_count climbs from 1 and holds at 7.
    sc = 3'd1;
    for (int i = 0; i < 7; i++) begin
      issue("sat_load", 0, lw3,  0, 0, 2'd0, 16'h0000, 0, ex_of(lw3), sc, 3'd2);
      if (sc != 3'd7) sc = sc + 3'd1;
      issue("sat_use",  0, use3, 0, 0, 2'd0, 16'h0000, 1, BUB,        sc, 3'd2);
    end

    issue("rst_load",      0, lw3,  0, 0, 2'd0, 16'h0000, 0, ex_of(lw3),  3'd7, 3'd2);
    issue("rst_mid_stall", 1, use3, 0, 0, 2'd0, 16'h0000, 0, BUB,         3'd0, 3'd0);
    issue("after_rst",     0, use3, 0, 0, 2'd0, 16'h0000, 0, ex_of(use3), 3'd0, 3'd0);

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected responses never compared", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
